// File: rtl/pc_pkg.sv
// Types and constants shared by the program-counter sequencer and its helpers.
package pc_pkg;

   localparam int PC_W = 7;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-successor adder: pc_in + STEP modulo 2^WIDTH, with the carry-out
// exposed so the sequencer can flag a wrap past the top of the address space.
module pc_incrementer
   import pc_pkg::*;
#(
   parameter int WIDTH = PC_W,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] full_sum;

   // One extra bit holds the carry-out of the increment.
   always_comb begin
      full_sum = {1'b0, pc_in} + (WIDTH+1)'(STEP);
   end

   assign sum   = full_sum[WIDTH-1:0];
   assign carry = full_sum[WIDTH];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with jump/branch/stall priority and a debug
// halt/single-step controller.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_RUN  | free-running fetch; halt_req moves to ST_HALT
//   ST_HALT | fetch disabled; PC only changes by jump; resume/step_req exit
//   ST_STEP | fetch enabled for exactly one unstalled advance, then ST_HALT
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int WIDTH        = PC_W,
   parameter int STEP         = 1,
   parameter int OFFSET_W     = 7,
   parameter int RESET_VECTOR = 0,
   parameter int BOOT_HALTED  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch_en,
   input  logic [OFFSET_W-1:0] branch_off,
   input  logic                jump_en,
   input  logic [WIDTH-1:0]    jump_addr,
   input  logic                halt_req,
   input  logic                step_req,
   input  logic                resume,
   output logic [WIDTH-1:0]    pc,
   output logic [WIDTH-1:0]    pc_next,
   output logic                fetch_en,
   output logic                halted,
   output logic                wrap
);

   localparam pc_state_e RESET_STATE = (BOOT_HALTED != 0) ? ST_HALT : ST_RUN;
   // Offset is sign-extended to at least the PC width before the add.
   localparam int EXT_W = (WIDTH > OFFSET_W) ? WIDTH : OFFSET_W;

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] pc_inc;
   logic             inc_carry;
   logic [EXT_W-1:0] off_ext;
   logic [EXT_W-1:0] br_sum;

   pc_incrementer #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_inc (
      .pc_in (pc_q),
      .sum   (pc_inc),
      .carry (inc_carry)
   );

   // Debug FSM next-state and the per-state fetch/halted outputs.
   always_comb begin
      state_d  = state_q;
      fetch_en = 1'b1;
      halted   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt_req) state_d = ST_HALT;
         end
         ST_HALT: begin
            fetch_en = 1'b0;
            halted   = 1'b1;
            if (resume)        state_d = ST_RUN;
            else if (step_req) state_d = ST_STEP;
         end
         ST_STEP: begin
            // Any unstalled cycle (sequential, branch or jump) is the one step.
            if (!stall) state_d = ST_HALT;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // Target select: jump beats everything, then hold, then branch, then increment.
   always_comb begin
      off_ext = EXT_W'($signed(branch_off));
      br_sum  = EXT_W'(pc_inc) + off_ext;
      pc_d    = pc_q;
      wrap_d  = 1'b0;
      if (jump_en) begin
         pc_d = jump_addr;
      end else if (!fetch_en || stall) begin
         pc_d = pc_q;
      end else if (branch_en) begin
         pc_d = br_sum[WIDTH-1:0];
      end else begin
         pc_d   = pc_inc;
         // Only the plain sequential path reports a wrap.
         wrap_d = inc_carry;
      end
   end

   // PC, FSM state and wrap pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= WIDTH'(RESET_VECTOR);
         state_q <= RESET_STATE;
         wrap_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

   assign pc      = pc_q;
   assign pc_next = pc_inc;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: default, boot-halted and wide/stride-4 instances.
module tb_pc_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance 0: defaults (WIDTH 7, STEP 1, RUN out of reset).
   logic       rst0, stall0, br0, jmp0, hr0, sr0, rs0;
   logic [6:0] off0, ja0, pc0, pcn0;
   logic       fe0, h0, w0;

   pc_sequencer dut0 (
      .clk(clk), .rst_n(rst0), .stall(stall0), .branch_en(br0), .branch_off(off0),
      .jump_en(jmp0), .jump_addr(ja0), .halt_req(hr0), .step_req(sr0), .resume(rs0),
      .pc(pc0), .pc_next(pcn0), .fetch_en(fe0), .halted(h0), .wrap(w0)
   );

   // Instance 1: boot halted at vector 5.
   logic       rst1, stall1, br1, jmp1, hr1, sr1, rs1;
   logic [6:0] off1, ja1, pc1, pcn1;
   logic       fe1, h1, w1;

   pc_sequencer #(.RESET_VECTOR(5), .BOOT_HALTED(1)) dut1 (
      .clk(clk), .rst_n(rst1), .stall(stall1), .branch_en(br1), .branch_off(off1),
      .jump_en(jmp1), .jump_addr(ja1), .halt_req(hr1), .step_req(sr1), .resume(rs1),
      .pc(pc1), .pc_next(pcn1), .fetch_en(fe1), .halted(h1), .wrap(w1)
   );

   // Instance 2: 12-bit PC, stride 4.
   logic        rst2, stall2, br2, jmp2, hr2, sr2, rs2;
   logic [6:0]  off2;
   logic [11:0] ja2, pc2, pcn2;
   logic        fe2, h2, w2;

   pc_sequencer #(.WIDTH(12), .STEP(4)) dut2 (
      .clk(clk), .rst_n(rst2), .stall(stall2), .branch_en(br2), .branch_off(off2),
      .jump_en(jmp2), .jump_addr(ja2), .halt_req(hr2), .step_req(sr2), .resume(rs2),
      .pc(pc2), .pc_next(pcn2), .fetch_en(fe2), .halted(h2), .wrap(w2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       stall, br;
      logic [6:0] off;
      logic       jmp;
      logic [6:0] ja;
      logic       hr, sr, rs;
      int         e_pc;
      logic       e_halt, e_wrap;
   } vec_t;

   function automatic vec_t mk(input logic stall, input logic br, input logic [6:0] off,
                               input logic jmp, input logic [6:0] ja, input logic hr,
                               input logic sr, input logic rs, input int e_pc,
                               input logic e_halt, input logic e_wrap);
      vec_t v;
      v.stall = stall; v.br = br; v.off = off; v.jmp = jmp; v.ja = ja;
      v.hr = hr; v.sr = sr; v.rs = rs; v.e_pc = e_pc; v.e_halt = e_halt; v.e_wrap = e_wrap;
      return v;
   endfunction

   // Reference model for instance 0, from the behavioural rules.
   int m_pc;
   bit m_halted, m_stepping, m_wrap;

   task automatic model_edge();
      int nxt;
      int sext;
      bit w;
      w = 0;
      sext = (off0 >= 7'd64) ? int'(off0) - 128 : int'(off0);
      if (jmp0)                      nxt = int'(ja0);
      else if (m_halted || stall0)   nxt = m_pc;
      else if (br0)                  nxt = (((m_pc + 1 + sext) % 128) + 128) % 128;
      else begin
         nxt = (m_pc + 1) % 128;
         w   = (m_pc + 1) >= 128;
      end
      if (m_stepping) begin
         if (!stall0) begin m_stepping = 0; m_halted = 1; end
      end else if (m_halted) begin
         if (rs0)      m_halted = 0;
         else if (sr0) begin m_halted = 0; m_stepping = 1; end
      end else if (hr0) begin
         m_halted = 1;
      end
      m_pc   = nxt;
      m_wrap = w;
   endtask

   vec_t tbl[$];

   initial begin
      int pulses;
      {stall0, br0, jmp0, hr0, sr0, rs0, off0, ja0} = '0;
      {stall1, br1, jmp1, hr1, sr1, rs1, off1, ja1} = '0;
      {stall2, br2, jmp2, hr2, sr2, rs2, off2, ja2} = '0;
      rst0 = 0; rst1 = 0; rst2 = 0;

      #12;
      chk("rst0 pc", pc0, 0);      chk("rst0 pc_next", pcn0, 1);
      chk("rst0 fetch", fe0, 1);   chk("rst0 halted", h0, 0);  chk("rst0 wrap", w0, 0);
      chk("rst1 pc", pc1, 5);      chk("rst1 pc_next", pcn1, 6);
      chk("rst1 fetch", fe1, 0);   chk("rst1 halted", h1, 1);
      chk("rst2 pc", pc2, 0);      chk("rst2 pc_next", pcn2, 4);
      rst0 = 1; rst1 = 1; rst2 = 1;

      // Free-run count through one full wrap.
      pulses = 0;
      for (int i = 1; i <= 130; i++) begin
         tick();
         chk($sformatf("count pc i=%0d", i), pc0, i % 128);
         chk($sformatf("count wrap i=%0d", i), w0, (i == 128) ? 1 : 0);
         if (w0) pulses++;
      end
      chk("count wrap pulses", pulses, 1);

      // Directed vector table on instance 0.
      //               stall br off    jmp ja     hr sr rs  pc  halt wrap
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd10,  0, 0, 0, 10,  0, 0));
      tbl.push_back(mk(0, 1, 7'h7C, 0, 7'd0,   0, 0, 0, 7,   0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd10,  0, 0, 0, 10,  0, 0));
      tbl.push_back(mk(1, 1, 7'h7C, 0, 7'd0,   0, 0, 0, 10,  0, 0));
      tbl.push_back(mk(1, 1, 7'h7C, 1, 7'd50,  0, 0, 0, 50,  0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd20,  0, 0, 0, 20,  0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   1, 0, 0, 21,  1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 21,  1, 0));
      tbl.push_back(mk(1, 0, 7'h00, 0, 7'd0,   0, 1, 0, 21,  0, 0));
      tbl.push_back(mk(1, 0, 7'h00, 0, 7'd0,   0, 0, 0, 21,  0, 0));
      tbl.push_back(mk(1, 0, 7'h00, 0, 7'd0,   0, 0, 0, 21,  0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 22,  1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 22,  1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 1, 1, 22,  0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 23,  0, 0));
      tbl.push_back(mk(0, 1, 7'h02, 0, 7'd0,   1, 0, 0, 26,  1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   1, 1, 0, 26,  0, 0));
      tbl.push_back(mk(0, 1, 7'h01, 0, 7'd0,   1, 0, 0, 28,  1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd100, 0, 0, 0, 100, 1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 1, 0, 100, 0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd5,   0, 0, 0, 5,   1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 1, 5,   0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd127, 0, 0, 0, 127, 0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 0,   0, 1));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 1,   0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 7'd126, 0, 0, 0, 126, 0, 0));
      tbl.push_back(mk(0, 1, 7'h03, 0, 7'd0,   0, 0, 0, 2,   0, 0));
      tbl.push_back(mk(1, 0, 7'h00, 0, 7'd0,   0, 0, 0, 2,   0, 0));
      tbl.push_back(mk(0, 1, 7'h7C, 0, 7'd0,   0, 0, 0, 127, 0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 7'd0,   0, 0, 0, 0,   0, 1));

      foreach (tbl[i]) begin
         stall0 = tbl[i].stall; br0 = tbl[i].br; off0 = tbl[i].off; jmp0 = tbl[i].jmp;
         ja0 = tbl[i].ja; hr0 = tbl[i].hr; sr0 = tbl[i].sr; rs0 = tbl[i].rs;
         tick();
         chk($sformatf("tbl[%0d] pc", i), pc0, tbl[i].e_pc);
         chk($sformatf("tbl[%0d] pc_next", i), pcn0, (tbl[i].e_pc + 1) % 128);
         chk($sformatf("tbl[%0d] halted", i), h0, tbl[i].e_halt);
         chk($sformatf("tbl[%0d] fetch", i), fe0, !tbl[i].e_halt);
         chk($sformatf("tbl[%0d] wrap", i), w0, tbl[i].e_wrap);
      end
      {stall0, br0, jmp0, hr0, sr0, rs0, off0, ja0} = '0;

      // Boot-halted instance: debugger jump, step with wrap, async resets.
      chk("boot pc", pc1, 5);  chk("boot halted", h1, 1);
      jmp1 = 1; ja1 = 7'd9;
      tick();
      jmp1 = 0;
      chk("boot jump pc", pc1, 9);  chk("boot jump fetch", fe1, 0);  chk("boot jump halted", h1, 1);
      sr1 = 1;
      tick();
      sr1 = 0;
      chk("boot step pc", pc1, 9);  chk("boot step halted", h1, 0);  chk("boot step fetch", fe1, 1);
      jmp1 = 1; ja1 = 7'd127; stall1 = 1;
      tick();
      jmp1 = 0; stall1 = 0;
      chk("step stalled jump pc", pc1, 127);  chk("step stalled jump halted", h1, 0);
      tick();
      chk("step wrap pc", pc1, 0);  chk("step wrap pulse", w1, 1);  chk("step done halted", h1, 1);
      #3 rst1 = 0;
      #1;
      chk("async rst wrap", w1, 0);  chk("async rst pc", pc1, 5);  chk("async rst halted", h1, 1);
      rst1 = 1;
      sr1 = 1; stall1 = 1;
      tick();
      sr1 = 0;
      chk("step2 halted", h1, 0);  chk("step2 pc", pc1, 5);
      tick();
      chk("step2 stalled halted", h1, 0);
      #2 rst1 = 0;
      #1;
      chk("rst in step pc", pc1, 5);  chk("rst in step halted", h1, 1);
      chk("rst in step fetch", fe1, 0);  chk("rst in step wrap", w1, 0);
      rst1 = 1; stall1 = 0;
      tick();
      chk("post rst pc", pc1, 5);  chk("post rst halted", h1, 1);

      // Wide/stride-4 instance around the top of the address space.
      jmp2 = 1; ja2 = 12'hFF4;
      tick();
      jmp2 = 0;
      chk("w12 jump pc", pc2, 12'hFF4);
      tick();  chk("w12 pc ff8", pc2, 12'hFF8);  chk("w12 wrap ff8", w2, 0);
      tick();  chk("w12 pc ffc", pc2, 12'hFFC);  chk("w12 pc_next ffc", pcn2, 12'h000);
      tick();  chk("w12 pc 000", pc2, 12'h000);  chk("w12 wrap 000", w2, 1);
      tick();  chk("w12 pc 004", pc2, 12'h004);  chk("w12 wrap 004", w2, 0);

      // Randomised run of instance 0 against the reference model.
      rst0 = 0;
      #1;
      rst0 = 1;
      m_pc = 0; m_halted = 0; m_stepping = 0; m_wrap = 0;
      for (int c = 0; c < 600; c++) begin
         stall0 = ($urandom_range(3) == 0);
         br0    = ($urandom_range(3) == 0);
         off0   = 7'($urandom);
         jmp0   = ($urandom_range(15) == 0);
         ja0    = ($urandom_range(1) == 0) ? 7'($urandom_range(127, 120)) : 7'($urandom);
         hr0    = ($urandom_range(15) == 0);
         sr0    = ($urandom_range(2) == 0);
         rs0    = ($urandom_range(3) == 0);
         model_edge();
         tick();
         chk($sformatf("rnd[%0d] pc", c), pc0, m_pc);
         chk($sformatf("rnd[%0d] pc_next", c), pcn0, (m_pc + 1) % 128);
         chk($sformatf("rnd[%0d] halted", c), h0, m_halted);
         chk($sformatf("rnd[%0d] fetch", c), fe0, !m_halted);
         chk($sformatf("rnd[%0d] wrap", c), w0, m_wrap);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It holds the registered PC and produces the sequential successor, PC + STEP. It applies branch, jump and stall requests with fixed priority, and adds a halt/single-step control FSM for the debug unit. It sits between the debug unit and the instruction memory address port, and generalises the fixed 7-bit +1 incrementer to configurable width, stride and offset width.

## Interface
- WIDTH, 7: PC width in bits; all PC arithmetic is modulo 2^WIDTH.
- STEP, 1: sequential stride added to the PC.
- OFFSET_W, 7: width of the signed branch offset.
- RESET_VECTOR, 0: PC value loaded on reset.
- BOOT_HALTED, 0: if 1, leave reset in HALT; otherwise leave reset in RUN.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- stall, input, 1: hold the PC (pipeline hazard).
- branch_en, input, 1: take a relative branch.
- branch_off, input, OFFSET_W: two's-complement offset, relative to pc_next.
- jump_en, input, 1: load an absolute target.
- jump_addr, input, WIDTH: absolute target.
- halt_req, input, 1: debug request to halt.
- step_req, input, 1: debug request to execute one instruction while halted.
- resume, input, 1: debug request to return to RUN.
- pc, output, WIDTH: registered current PC.
- pc_next, output, WIDTH: combinational pc + STEP, mod 2^WIDTH.
- fetch_en, output, 1: PC is live for fetch this cycle.
- halted, output, 1: FSM is in HALT.
- wrap, output, 1: registered one-cycle pulse when a sequential increment wrapped past 2^WIDTH−1.

## Operation
FSM states are RUN, HALT and STEP.

Outputs per state:
- fetch_en = 1 in RUN and STEP; 0 in HALT.
- halted = 1 only in HALT.

FSM transitions:
- RUN → HALT when halt_req = 1. The PC update in that cycle still happens normally.
- HALT → RUN when resume = 1. resume has priority over step_req.
- HALT → STEP when step_req = 1 and resume = 0.
- STEP → HALT on the first cycle with stall = 0, i.e. after exactly one advance. STEP remains in STEP while stall = 1. halt_req is ignored in STEP.

PC update priority, evaluated each cycle:
1. jump_en: pc ← jump_addr. Honoured in every state, including HALT, so the debugger can load the PC.
2. If fetch_en = 0: hold.
3. If stall = 1: hold. branch_en is ignored while stalled.
4. If branch_en = 1: pc ← pc_next + sign_extend(branch_off), truncated to WIDTH.
5. Otherwise: pc ← pc_next.

Other rules:
- A jump in STEP counts as the step's advance when stall = 0.
- wrap is set for one cycle only when path 5 was taken with pc + STEP ≥ 2^WIDTH. Branch or jump wrap-around is silent.

## Timing
- Reset values (asynchronous): pc = RESET_VECTOR, state = HALT if BOOT_HALTED else RUN, wrap = 0.
- Reset values of the derived outputs: fetch_en = !BOOT_HALTED, halted = BOOT_HALTED, pc_next = RESET_VECTOR + STEP.
- Asserting rst_n low mid-operation, including mid-STEP, aborts immediately to these values. No pending request survives reset.
- Latency: any redirect presented in cycle N is visible on pc in cycle N+1. pc_next follows pc combinationally with zero latency.
- halted and fetch_en change in the cycle after the triggering request.
- All control inputs are level-sampled on each edge; no handshake acknowledgement is generated.
- Simultaneous inputs:
  - jump_en with branch_en: jump wins.
  - halt_req with a redirect in RUN: the redirect is applied, then the FSM enters HALT.

## Structure
- Shared package pc_pkg: state enum (RUN, HALT, STEP) and a default-width constant PC_W = 7.
- Sub-module pc_incrementer (WIDTH, STEP): combinational sum plus carry-out. The carry-out feeds the wrap logic.
- Everything else lives in pc_sequencer: target mux, PC register, FSM, wrap register.

## Test plan
- Reset and count: defaults, release rst_n, 130 cycles idle → pc counts 0..127 then 0, 1, 2; wrap pulses exactly once, in the cycle pc = 0 after 127.
- Branch: at pc = 10, branch_en with branch_off = 7'h7C (−4) → next pc = 7. With stall = 1 in the same cycle → pc stays 10.
- Priority: jump_en with jump_addr = 50, branch_en = 1, stall = 1 in the same cycle → next pc = 50.
- Halt/step: halt_req at pc = 20 → pc = 21 then holds, halted = 1. step_req with stall = 1 for 2 cycles → pc holds, then pc = 22, then HALT again. resume with step_req → RUN, pc advances.
- Boot and reset mid-operation: BOOT_HALTED = 1, RESET_VECTOR = 5 → pc = 5, halted = 1. Jump to 9 while halted → pc = 9, fetch_en = 0. Assert rst_n low in STEP → pc = 5, HALT, wrap = 0 asynchronously.
- Parameter sweep: WIDTH = 12, STEP = 4 → increments of 4; at pc = 0xFFC, wrap pulses with pc = 0x000.
